// File: rtl/pipeline_run_ctrl.sv
// pipeline_run_ctrl: run controller for the pipelined MIPS core.
// It sequences a multi-cycle CPU reset on start and counts RUN cycles.
// Every change of resultbuf is captured into a circular trace buffer.
// The run ends on a quiescent result (halt) or on a cycle timeout.
// Optional feature: define RUN_CTRL_SIG_EN to build the rotate-xor run signature;
// when it is undefined, signature is tied to 0.
module pipeline_run_ctrl #(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 8,
  parameter int RST_CYCLES = 4,
  parameter int HALT_IDLE  = 16,
  parameter int TIMEOUT    = 1024,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1,
  localparam int IW = $clog2(HALT_IDLE + 1),
  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic              start,
  input  logic [DATA_W-1:0] resultbuf,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [31:0]       cycle_cnt,
  output logic [DATA_W-1:0] last_result,
  output logic [CW-1:0]     trace_count,
  input  logic [AW-1:0]     trace_rd_idx,
  output logic [DATA_W-1:0] trace_rd_data,
  output logic [DATA_W-1:0] signature
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RESET = 3'd1,
    S_RUN   = 3'd2,
    S_DONE  = 3'd3,
    S_TMO   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                cpu_rst_q;
  logic [RW-1:0]       rst_cnt_q;
  logic [IW-1:0]       idle_cnt_q;
  logic [AW-1:0]       wr_ptr_q;
  logic [DATA_W-1:0]   trace_mem [DEPTH];

  logic                clear;
  logic                in_run;
  logic                changed;
  logic                halt_hit;
  logic                tmo_hit;
  logic                full;
  logic [AW-1:0]       rd_addr;

  // Trace occupancy stops growing once the buffer is full.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == CW'(DEPTH)) ? c : c + CW'(1);
  endfunction

  assign in_run   = (state_q == S_RUN);
  assign changed  = (resultbuf != last_result);
  assign halt_hit = !changed && ((idle_cnt_q + IW'(1)) == IW'(HALT_IDLE));
  assign tmo_hit  = ((cycle_cnt + 32'd1) == 32'(TIMEOUT));
  assign clear    = start && ((state_q == S_IDLE) || (state_q == S_DONE) ||
                              (state_q == S_TMO));

  // Next-state decode; timeout takes priority over halt on the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_TMO: if (start) state_d = S_RESET;
      S_RESET: if (rst_cnt_q == RW'(RST_CYCLES - 1)) state_d = S_RUN;
      S_RUN: begin
        if (tmo_hit)       state_d = S_TMO;
        else if (halt_hit) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register and registered CPU reset (released only while running).
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state_q   <= S_IDLE;
      cpu_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cpu_rst_q <= (state_d != S_RUN);
    end
  end

  // Counts cycles spent holding the CPU in reset.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst)                    rst_cnt_q <= '0;
    else if (state_q == S_RESET) rst_cnt_q <= rst_cnt_q + RW'(1);
    else                         rst_cnt_q <= '0;
  end

  // Run-cycle and idle counters, cleared when a new run is requested.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      cycle_cnt  <= '0;
      idle_cnt_q <= '0;
    end else if (clear) begin
      cycle_cnt  <= '0;
      idle_cnt_q <= '0;
    end else if (in_run) begin
      cycle_cnt  <= cycle_cnt + 32'd1;
      idle_cnt_q <= changed ? '0 : idle_cnt_q + IW'(1);
    end
  end

  // Capture bookkeeping: write pointer, occupancy and last captured value.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      wr_ptr_q    <= '0;
      trace_count <= '0;
      last_result <= '0;
    end else if (clear) begin
      wr_ptr_q    <= '0;
      trace_count <= '0;
      last_result <= '0;
    end else if (in_run && changed) begin
      wr_ptr_q    <= wr_ptr_q + AW'(1);
      trace_count <= sat_inc(trace_count);
      last_result <= resultbuf;
    end
  end

  // Trace storage; stale contents are hidden by trace_count on readout.
  always_ff @(posedge clk) begin
    if (in_run && changed) trace_mem[wr_ptr_q] <= resultbuf;
  end

  // Once full, the oldest entry sits at the write pointer.
  assign full          = (trace_count == CW'(DEPTH));
  assign rd_addr       = full ? (wr_ptr_q + trace_rd_idx) : trace_rd_idx;
  assign trace_rd_data = ({1'b0, trace_rd_idx} < trace_count) ? trace_mem[rd_addr]
                                                              : '0;

`ifdef RUN_CTRL_SIG_EN
  logic [DATA_W-1:0] sig_q;

  // One-bit rotate left, the mixing step of the signature.
  function automatic logic [DATA_W-1:0] rotl1(input logic [DATA_W-1:0] v);
    return {v[DATA_W-2:0], v[DATA_W-1]};
  endfunction

  // Signature folds every captured value into a rotate-xor checksum.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst)                    sig_q <= '0;
    else if (clear)              sig_q <= '0;
    else if (in_run && changed)  sig_q <= rotl1(sig_q) ^ resultbuf;
  end

  assign signature = sig_q;
`else
  assign signature = '0;
`endif

  assign cpu_rst = cpu_rst_q;
  assign busy    = (state_q == S_RESET) || (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
  assign timeout = (state_q == S_TMO);

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Testbench for pipeline_run_ctrl: directed vectors with hand-computed results.
// Inputs change 1 ns after the rising edge; outputs are checked there too.
module tb_pipeline_run_ctrl;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = AW + 1;

  logic              clk = 1'b0;
  logic              Rst = 1'b1;
  logic              start = 1'b0;
  logic [DATA_W-1:0] resultbuf = '0;
  logic              cpu_rst, busy, done, timeout;
  logic [31:0]       cycle_cnt;
  logic [DATA_W-1:0] last_result;
  logic [CW-1:0]     trace_count;
  logic [AW-1:0]     trace_rd_idx = '0;
  logic [DATA_W-1:0] trace_rd_data;
  logic [DATA_W-1:0] signature;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] esig;

  pipeline_run_ctrl #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .RST_CYCLES(4), .HALT_IDLE(16), .TIMEOUT(100)
  ) dut (
    .clk(clk), .Rst(Rst), .start(start), .resultbuf(resultbuf),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .timeout(timeout),
    .cycle_cnt(cycle_cnt), .last_result(last_result), .trace_count(trace_count),
    .trace_rd_idx(trace_rd_idx), .trace_rd_data(trace_rd_data), .signature(signature)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] sig_step(input logic [DATA_W-1:0] s,
                                                 input logic [DATA_W-1:0] v);
`ifdef RUN_CTRL_SIG_EN
    return {s[DATA_W-2:0], s[DATA_W-1]} ^ v;
`else
    return '0;
`endif
  endfunction

  task automatic rd(input string tag, input int idx, input logic [31:0] exp);
    trace_rd_idx = AW'(idx);
    #1;
    chk(tag, trace_rd_data, exp);
  endtask

  // Pulse start and wait (bounded) until the CPU reset is released.
  task automatic run_start(output int rst_len);
    rst_len = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (cpu_rst && rst_len < 12) begin
      rst_len++;
      tick();
    end
  endtask

  task automatic wait_end();
    int k;
    k = 0;
    while (!done && !timeout && k < 150) begin
      k++;
      tick();
    end
    if (k >= 150) chk("wait_end_bound", 32'(k), 32'd0);
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_cpu_rst"}, cpu_rst, 1);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_done"}, done, 0);
    chk({pfx, "_timeout"}, timeout, 0);
    chk({pfx, "_cycle_cnt"}, cycle_cnt, 0);
    chk({pfx, "_trace_count"}, trace_count, 0);
    chk({pfx, "_last_result"}, last_result, 0);
    chk({pfx, "_signature"}, signature, 0);
    chk({pfx, "_rd_data"}, trace_rd_data, 0);
  endtask

  initial begin
    int len;
    // Power-on reset
    #1 Rst = 1'b0;
    #1 chk_reset_vals("por");
    #5 Rst = 1'b1;
    tick();
    tick();
    chk("idle_cpu_rst", cpu_rst, 1);
    chk("idle_busy", busy, 0);

    // Reset sequencing: cpu_rst held exactly 4 cycles, then RUN
    run_start(len);
    chk("rst_len", 32'(len), 4);
    chk("run_busy", busy, 1);
    chk("run_cpu_rst", cpu_rst, 0);
    chk("run_cycle0", cycle_cnt, 0);

    // Halt: 5,5,9,12 then constant 12
    esig = '0;
    resultbuf = 5; tick(); esig = sig_step(esig, 5);
    chk("cap1_count", trace_count, 1);
    chk("cap1_last", last_result, 5);
    resultbuf = 5;  tick();
    resultbuf = 9;  tick(); esig = sig_step(esig, 9);
    resultbuf = 12; tick(); esig = sig_step(esig, 12);
    wait_end();
    chk("halt_done", done, 1);
    chk("halt_timeout", timeout, 0);
    chk("halt_cycles", cycle_cnt, 20);
    chk("halt_cpu_rst", cpu_rst, 1);
    chk("halt_busy", busy, 0);
    chk("halt_count", trace_count, 3);
    chk("halt_sig", signature, esig);
    rd("halt_rd0", 0, 5);
    rd("halt_rd1", 1, 9);
    rd("halt_rd2", 2, 12);
    rd("halt_rd3_empty", 3, 0);

    // Wrap: values 1..11 with DEPTH 8, restarted from DONE
    run_start(len);
    chk("wrap_clr_cycles", cycle_cnt, 0);
    chk("wrap_clr_count", trace_count, 0);
    chk("wrap_clr_last", last_result, 0);
    chk("wrap_clr_sig", signature, 0);
    esig = '0;
    for (int v = 1; v <= 11; v++) begin
      resultbuf = DATA_W'(v);
      tick();
      esig = sig_step(esig, DATA_W'(v));
    end
    wait_end();
    chk("wrap_done", done, 1);
    chk("wrap_cycles", cycle_cnt, 27);
    chk("wrap_count", trace_count, 8);
    chk("wrap_last", last_result, 11);
    chk("wrap_sig", signature, esig);
    rd("wrap_rd0", 0, 4);
    rd("wrap_rd3", 3, 7);
    rd("wrap_rd7", 7, 11);

    // Timeout: leading zeros record nothing, start in RUN is ignored
    run_start(len);
    esig = '0;
    resultbuf = 0;
    tick();
    tick();
    chk("zero_count", trace_count, 0);
    chk("zero_last", last_result, 0);
    chk("zero_cycles", cycle_cnt, 2);
    for (int v = 1; v <= 200 && !timeout; v++) begin
      resultbuf = DATA_W'(v);
      start = (v == 10);
      tick();
      start = 1'b0;
      esig = sig_step(esig, DATA_W'(v));
      if (v == 10) begin
        chk("start_ign_cycles", cycle_cnt, 12);
        chk("start_ign_busy", busy, 1);
        chk("start_ign_cpu_rst", cpu_rst, 0);
      end
    end
    chk("tmo_timeout", timeout, 1);
    chk("tmo_done", done, 0);
    chk("tmo_cycles", cycle_cnt, 100);
    chk("tmo_last", last_result, 98);
    chk("tmo_sig", signature, esig);
    resultbuf = 500;
    tick(); tick(); tick();
    chk("tmo_hold_cycles", cycle_cnt, 100);
    chk("tmo_hold_last", last_result, 98);
    chk("tmo_hold_flag", timeout, 1);
    chk("tmo_hold_cpu_rst", cpu_rst, 1);
    rd("tmo_rd0", 0, 91);
    rd("tmo_rd7", 7, 98);

    // Halt and timeout on the same cycle: timeout wins
    run_start(len);
    for (int v = 1; v <= 84; v++) begin
      resultbuf = DATA_W'(v);
      tick();
    end
    wait_end();
    chk("tie_timeout", timeout, 1);
    chk("tie_done", done, 0);
    chk("tie_cycles", cycle_cnt, 100);
    rd("tie_rd0", 0, 77);

    // Asynchronous reset mid-run, then a clean run
    run_start(len);
    resultbuf = 3; tick();
    resultbuf = 4; tick();
    chk("pre_rst_count", trace_count, 2);
    trace_rd_idx = '0;
    Rst = 1'b0;
    #1 chk_reset_vals("async");
    #3 Rst = 1'b1;
    tick();
    chk("post_rst_idle_busy", busy, 0);
    run_start(len);
    chk("rerun_rst_len", 32'(len), 4);
    esig = '0;
    resultbuf = 1; tick(); esig = sig_step(esig, 1);
    chk("sig_after1", signature, esig);
    resultbuf = 2; tick(); esig = sig_step(esig, 2);
    chk("sig_after2", signature, 0);
    chk("rerun_count", trace_count, 2);
    chk("rerun_cycles", cycle_cnt, 2);
    rd("rerun_rd0", 0, 1);
    rd("rerun_rd1", 1, 2);
    rd("rerun_rd2_empty", 2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_run_ctrl.md
# pipeline_run_ctrl

Synthesisable run controller for the pipelined MIPS core, wrapped around the CPU's `resultbuf` output. It sequences a multi-cycle CPU reset on `start` and counts run cycles. It captures every change of `resultbuf` into a circular trace buffer and ends the run on a quiescent result (halt) or on a cycle timeout. It replaces free-running clock/reset stimulus with a parametrised, on-chip-usable equivalent.

## Interface
Parameters:
- `DATA_W`, 32, width of `resultbuf` and trace entries
- `DEPTH`, 8, trace buffer entries; power of two, ≥2
- `RST_CYCLES`, 4, cycles `cpu_rst` is held high; ≥1
- `HALT_IDLE`, 16, consecutive unchanged-result cycles that declare halt; ≥1
- `TIMEOUT`, 1024, run-cycle limit; must be > `HALT_IDLE`

Ports:
- `clk`  in  1  clock; all logic rising-edge
- `Rst`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request to begin a run
- `resultbuf`  in  DATA_W  CPU result bus
- `cpu_rst`  out  1  active-high reset to CPU
- `busy`  out  1  high in RESET or RUN
- `done`  out  1  high in DONE
- `timeout`  out  1  high in TMO
- `cycle_cnt`  out  32  RUN cycles elapsed this run
- `last_result`  out  DATA_W  most recently captured value
- `trace_count`  out  clog2(DEPTH)+1  valid entries, saturates at DEPTH
- `trace_rd_idx`  in  clog2(DEPTH)  read index, 0 = oldest valid entry
- `trace_rd_data`  out  DATA_W  entry at `trace_rd_idx`, combinational
- `signature`  out  DATA_W  run checksum (see Configuration)

## Operation
- States: IDLE, RESET, RUN, DONE, TMO.
- IDLE: `start` → RESET. Clears `cycle_cnt`, the trace, the idle counter, the signature and `last_result`.
- RESET: `cpu_rst`=1 for exactly RST_CYCLES cycles, then → RUN.
- RUN: `cycle_cnt` increments every cycle.
  - If `resultbuf` ≠ `last_result`, write it at the write pointer and advance the pointer (wraps mod DEPTH). Then increment `trace_count` (saturating), update `last_result`, and clear the idle counter.
  - Otherwise the idle counter increments.
  - Idle counter reaching HALT_IDLE → DONE.
  - `cycle_cnt` reaching TIMEOUT → TMO. TMO wins if both conditions occur on the same cycle.
- Full trace: a new entry overwrites the oldest entry. Index 0 then maps to the write pointer.
- DONE/TMO: outputs hold. `start` → RESET with all clears as from IDLE.
- `start` in RESET or RUN is ignored.
- `trace_rd_idx` ≥ `trace_count` returns 0.
- The first capture compares against the reset value 0. A program whose first result is 0 therefore records nothing until the value changes.

## Timing
- Values after `Rst` low: state IDLE, `cpu_rst`=1, `busy`=0, `done`=0, `timeout`=0, all counters, `last_result`, `signature` and trace = 0. The CPU is held in reset while the controller is in reset or IDLE.
- `cpu_rst` is 1 in IDLE, RESET, DONE and TMO, and 0 only in RUN. It is registered.
- `start` sampled at edge n → RESET from edge n+1 through n+RST_CYCLES. RUN begins at edge n+RST_CYCLES+1.
- `resultbuf` is sampled at each edge while in RUN. A capture is visible on `trace_count`/`last_result` one cycle later.
- DONE asserts on the edge after the HALT_IDLE-th unchanged cycle. TMO asserts on the edge where `cycle_cnt` would become TIMEOUT, so `cycle_cnt` then reads TIMEOUT.
- `Rst` low mid-run forces IDLE immediately (asynchronous) and discards the trace.

## Configuration
- `RUN_CTRL_SIG_EN` defined: on each capture, `signature` ← {signature[DATA_W-2:0], signature[DATA_W-1]} ^ captured value. The result is held in DONE/TMO.
- Not defined: no signature logic is built and `signature` is tied to 0.

## Test plan
- Reset then `start`, DEPTH=8, RST_CYCLES=4 → `cpu_rst` high for exactly 4 cycles after `start`, then low with `busy`=1.
- `resultbuf` sequence 5, 5, 9, 12, then constant; HALT_IDLE=16 → `trace_count`=3, trace reads 5, 9, 12, `done`=1 after 16 idle cycles, `cpu_rst`=1.
- 11 distinct values 1..11 with DEPTH=8 → `trace_count`=8, index 0 reads 4, index 7 reads 11.
- `resultbuf` changing every cycle with TIMEOUT=100 → `timeout`=1, `cycle_cnt`=100, `done`=0.
- `Rst` pulsed low mid-RUN → all outputs at reset values in the same cycle. A new `start` runs a clean sequence.
- `RUN_CTRL_SIG_EN` defined, captures 0x1, 0x2 → `signature`=0x0 (rotate(1)=2, 2^2=0). Macro undefined → `signature`=0.
